// File: rtl/seq_adder_pkg.sv
// Shared types and helpers for the sequential wide adder.
package seq_adder_pkg;

  // Operation phases: waiting for operands, streaming slices, holding result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to index k slices; never less than one so a K=1 build
  // still has a real counter register.
  function automatic int cnt_width(input int k);
    int w;
    w = 1;
    while ((1 << w) < k) w++;
    return w;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational N-bit carry-look-ahead adder slice.
module cla_slice #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;

  // Per-bit generate/propagate and the look-ahead carry recurrence.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    sum  = p ^ c[N-1:0];
    cout = c[N];
  end

endmodule

// File: rtl/seq_wide_adder.sv
// Multi-cycle W-bit adder: operands are consumed N bits per cycle, LSB
// slice first, through one cla_slice with the carry registered between
// cycles.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready and out_valid depend only on state (and rst_n for
// in_ready), never on in_valid/out_ready. Once out_valid rises, sum/cout/
// overflow stay fixed until the result transfer.
module seq_wide_adder
  import seq_adder_pkg::*;
#(
  parameter int W = 32,
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         overflow,
  output logic [1:0]   dbg_state_o
);

  localparam int K  = W / N;
  localparam int CW = cnt_width(K);

  if (W % N != 0) begin : g_bad_width
    $error("seq_wide_adder: W must be a multiple of N");
  end

  state_t         state_q, state_d;
  logic [W-1:0]   a_sh_q, a_sh_d;
  logic [W-1:0]   b_sh_q, b_sh_d;
  logic [W-1:0]   sum_sh_q, sum_sh_d;
  logic           carry_q, carry_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           a_msb_q, a_msb_d;
  logic           b_msb_q, b_msb_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;

  logic [N-1:0]   slice_sum;
  logic           slice_cout;
  logic [W-1:0]   sum_shift;
  logic [W-1:0]   a_next;
  logic [W-1:0]   b_next;

  cla_slice #(.N(N)) u_cla (
    .a    (a_sh_q[N-1:0]),
    .b    (b_sh_q[N-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // With a single slice there is nothing left to shift in from above.
  if (K == 1) begin : g_one_slice
    assign sum_shift = slice_sum;
    assign a_next    = '0;
    assign b_next    = '0;
  end else begin : g_multi_slice
    assign sum_shift = {slice_sum, sum_sh_q[W-1:N]};
    assign a_next    = {{N{1'b0}}, a_sh_q[W-1:N]};
    assign b_next    = {{N{1'b0}}, b_sh_q[W-1:N]};
  end

  assign in_ready    = (state_q == IDLE) && rst_n;
  assign out_valid   = (state_q == DONE);
  assign sum         = sum_q;
  assign cout        = cout_q;
  assign overflow    = ovf_q;
  assign dbg_state_o = state_q;

  // Next-state and datapath update for accept, slice streaming and result hold.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_d = RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          a_msb_d = a[W-1];
          b_msb_d = b[W-1];
        end
      end
      RUN: begin
        carry_d  = slice_cout;
        sum_sh_d = sum_shift;
        a_sh_d   = a_next;
        b_sh_d   = b_next;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(K - 1)) begin
          state_d = DONE;
          sum_d   = sum_shift;
          cout_d  = slice_cout;
          ovf_d   = (a_msb_q == b_msb_q) && (sum_shift[W-1] != a_msb_q);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any operation and clears all datapath state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: doc/seq_wide_adder.md
# seq_wide_adder

Multi-cycle wide adder that accepts W-bit operand pairs over a valid/ready handshake and streams them, N bits per cycle (LSB slice first), through a single N-bit carry-look-ahead slice. The slice carry-out is registered between cycles. The block sits upstream of the datapath consumers of wide sums and trades latency for area: one N-bit CLA instead of a full W-bit one. It returns the full W-bit sum, carry-out and signed overflow over a second valid/ready handshake.

## Interface
- W, 32, operand/sum width; W % N == 0 required (elaboration error otherwise)
- N, 8, slice width handled per cycle; K = W/N slices per operation
- clk  input  1  rising-edge clock, the only clock
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  operand pair and cin valid
- in_ready  output  1  block can accept an operation
- a  input  W  operand A
- b  input  W  operand B
- cin  input  1  carry-in into bit 0
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  W  A + B + cin, modulo 2^W
- cout  output  1  carry out of bit W-1
- overflow  output  1  two's-complement overflow: (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1])

## Operation
- States: IDLE, RUN, DONE.
  - IDLE: in_ready = 1. On in_valid && in_ready: latch a and b into shift registers, carry_q <= cin, slice counter <= 0, latch the two operand MSBs for overflow, go to RUN.
  - RUN: each cycle, compute slice = a_sh[N-1:0] + b_sh[N-1:0] + carry_q through the CLA slice.
    - carry_q <= slice carry-out.
    - sum_sh <= {slice_sum, sum_sh[W-1:N]}.
    - a_sh and b_sh shift right by N.
    - Counter increments; when counter == K-1, go to DONE.
  - DONE: out_valid = 1; sum = sum_sh, cout = carry_q, overflow per the formula. On out_valid && out_ready, go to IDLE.
- in_ready = 1 only in IDLE and only while rst_n = 1. Inputs presented in RUN or DONE are ignored.
- sum, cout and overflow hold stable while out_valid = 1 and out_ready = 0. They keep their last value in IDLE; consumers must qualify them with out_valid.
- K = 1 (N == W) is legal: RUN lasts one cycle.
- Slice counter width is max(1, clog2(K)).
- Reset (rst_n = 0 at a clock edge), in any state including mid-RUN or DONE, aborts the operation with no partial result emitted. After that edge:
  - state = IDLE
  - out_valid = 0
  - sum, cout, overflow, carry_q, counter and shift registers = 0
  - in_ready = 0 while rst_n is low, and 1 in the first cycle after rst_n returns high.

## Timing
- Accept edge E0 (in_valid && in_ready sampled high).
- Edges E1..EK process slices 0..K-1.
- out_valid rises in the cycle following EK: K cycles after the accept cycle.
- Result handshake edge Eh (out_valid && out_ready high). in_ready = 1 in the cycle after Eh.
- With out_ready tied high, throughput is one operation per K+2 cycles.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- All outputs are registered or decoded from state only.
- Critical path is one N-bit CLA plus the carry_q register.

## Structure
- Shared package seq_adder_pkg holds the state typedef (IDLE, RUN, DONE) and a clog2-style width helper function.
- One sub-module, cla_slice: a purely combinational N-bit carry-look-ahead adder.
  - Ports: a, b, cin, sum, cout.
  - Per-bit generate/propagate, with carry chain Ci[i+1] = G[i] | (P[i] & Ci[i]).
- All sequencing stays in seq_wide_adder.

## Test plan
- Use W=32, N=8 unless stated.
- a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, overflow=0; out_valid asserted exactly 4 cycles after the accept cycle.
- a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, overflow=1.
- a=0x12345678, b=0x11111111, cin=1 -> sum=0x2345678A, cout=0, overflow=0.
- Backpressure: result 0x2345678A held with out_ready=0 for 5 cycles -> sum, cout and out_valid stable; in_ready=0; a new in_valid pulse with a=b=0xFFFFFFFF is ignored. Release out_ready -> in_ready=1 the next cycle.
- Reset mid-RUN, after 2 slices: next cycle out_valid=0 and sum=0; in_ready=1 once rst_n is high. A following op with a=0x00000005, b=0x00000003, cin=0 -> sum=0x00000008, cout=0.
- Parameter N=W=32: a=0x80000000, b=0x80000000, cin=0 -> sum=0, cout=1, overflow=1; out_valid 1 cycle after the accept cycle.
